// File: rtl/phase_pkg.sv
// Shared phase constants, FSM state encoding and octant flags for phase_detect.
// The phase unit is shared with the rotator: OPI == pi.
package phase_pkg;

    localparam int OPI  = 1608;
    localparam int DPI  = 2 * OPI;
    localparam int HPI  = OPI / 2;
    localparam int QPI  = OPI / 4;
    localparam int TQPI = 3 * OPI / 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FOLD,
        ST_DIV,
        ST_LOOK,
        ST_CAPT,
        ST_OUT
    } state_e;

    // Octant the sample was folded from; undone at the output.
    typedef struct packed {
        logic sign_i;
        logic sign_q;
        logic swap;
    } oct_t;

endpackage

// File: rtl/phase_detect_frac_div.sv
// Iterative restoring fractional divider: quot = floor(num * 2**W / den).
// The first quotient bit is produced on the start edge, so W edges in total.
// The caller guarantees num < den, so the quotient fits in W bits.
module frac_div #(
    parameter int W  = 9,
    parameter int NW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [NW-1:0] num,
    input  logic [NW-1:0] den,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  quot
);

    localparam int CW = $clog2(W + 1);

    logic [NW:0]   rem_q;
    logic [NW-1:0] den_q;
    logic [W-1:0]  quot_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    logic [NW:0]   rem_src;
    logic [NW:0]   rem_sh;
    logic [NW:0]   den_ext;
    logic [NW:0]   rem_d;
    logic [W-1:0]  quot_d;
    logic          ge;

    // One restoring step: shift remainder, subtract divisor if it fits.
    always_comb begin
        rem_src = start ? {1'b0, num} : rem_q;
        den_ext = start ? {1'b0, den} : {1'b0, den_q};
        rem_sh  = rem_src << 1;
        ge      = (rem_sh >= den_ext);
        rem_d   = ge ? (rem_sh - den_ext) : rem_sh;
        quot_d  = ((start ? '0 : quot_q) << 1) | W'(ge);
    end

    // Load on start, then iterate until W quotient bits are done.
    always_ff @(posedge clock) begin
        if (reset) begin
            rem_q  <= '0;
            den_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q  <= rem_d;
                quot_q <= quot_d;
                den_q  <= den;
                cnt_q  <= CW'(W - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q  <= rem_d;
                quot_q <= quot_d;
                cnt_q  <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign quot = quot_q;

endmodule

// File: rtl/phase_detect.sv
// Phase detector: folds (in_i, in_q) into the first octant, divides min/max,
// looks the ratio up in an external arctan ROM and unfolds to -OPI..+OPI.
// Optional feature macro: PHASE_DETECT_MAG_EN adds the alpha-max-beta-min
// magnitude output 'mag'.
import phase_pkg::*;

module phase_detect #(
    parameter int ATAN_WIDTH = 9,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ivalid,
    output logic                  iready,
    input  logic [DATA_WIDTH-1:0] in_i,
    input  logic [DATA_WIDTH-1:0] in_q,
    output logic [ATAN_WIDTH-1:0] atan_addr,
    input  logic [15:0]           atan_data,
    output logic                  ovalid,
    output logic signed [15:0]    phase
`ifdef PHASE_DETECT_MAG_EN
    ,
    output logic [DATA_WIDTH:0]   mag
`endif
);

    localparam int DW = DATA_WIDTH;

    // |v| with the most negative code clamped to the most positive one.
    function automatic logic [DW-1:0] abs_sat(input logic [DW-1:0] v);
        if (!v[DW-1])
            return v;
        else if (v == {1'b1, {(DW-1){1'b0}}})
            return {1'b0, {(DW-1){1'b1}}};
        else
            return -v;
    endfunction

    state_e                state_q;
    logic                  iready_q;
    logic                  ovalid_q;
    logic signed [15:0]    phase_q;
    logic [ATAN_WIDTH-1:0] atan_addr_q;
    logic [DW-1:0]         in_i_q;
    logic [DW-1:0]         in_q_q;
    oct_t                  oct_q;
    logic                  byp_q;
    logic [15:0]           byp_a_q;

    logic [DW-1:0]         ax, ay, fx, fy;
    oct_t                  oct_d;
    logic                  byp_d;
    logic [15:0]           byp_a_d;
    logic [15:0]           a_d;
    logic signed [16:0]    p_ang, p_swp, p_si, p_sq;
    logic signed [15:0]    phase_d;

    logic                  div_busy;
    logic                  div_done;
    logic [ATAN_WIDTH-1:0] div_quot;

    // Fold into the first octant; equal and zero-minor cases skip the ROM.
    always_comb begin
        ax           = abs_sat(in_i_q);
        ay           = abs_sat(in_q_q);
        oct_d.sign_i = in_i_q[DW-1];
        oct_d.sign_q = in_q_q[DW-1];
        oct_d.swap   = (ay > ax);
        fx           = oct_d.swap ? ay : ax;
        fy           = oct_d.swap ? ax : ay;
        byp_d        = (fy == '0) || (fx == fy);
        byp_a_d      = (fy == '0) ? 16'd0 : 16'(QPI);
    end

    frac_div #(
        .W  (ATAN_WIDTH),
        .NW (DW)
    ) u_div (
        .clock (clock),
        .reset (reset),
        .start (state_q == ST_FOLD),
        .num   (fy),
        .den   (fx),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot)
    );

    // Unfold the first-octant angle; in_q == 0 never sets sign_q, so -OPI cannot occur.
    always_comb begin
        a_d     = byp_q ? byp_a_q : atan_data;
        p_ang   = signed'({1'b0, a_d});
        p_swp   = oct_q.swap   ? (17'(HPI) - p_ang) : p_ang;
        p_si    = oct_q.sign_i ? (17'(OPI) - p_swp) : p_swp;
        p_sq    = oct_q.sign_q ? -p_si : p_si;
        phase_d = 16'(p_sq);
    end

`ifdef PHASE_DETECT_MAG_EN
    logic [DW:0] mag_f_d;
    logic [DW:0] mag_f_q;
    logic [DW:0] mag_q;

    // max + min/4 + min/8 on the folded pair.
    always_comb begin
        mag_f_d = {1'b0, fx} + {1'b0, fy >> 2} + {1'b0, fy >> 3};
    end

    // Magnitude is computed in FOLD and published alongside the phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            mag_f_q <= '0;
            mag_q   <= '0;
        end else begin
            if (state_q == ST_FOLD)
                mag_f_q <= mag_f_d;
            if (state_q == ST_CAPT)
                mag_q <= mag_f_q;
        end
    end

    assign mag = mag_q;
`endif

    // Control FSM; the ROM word arriving in CAPT goes straight into the phase register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            iready_q    <= 1'b1;
            ovalid_q    <= 1'b0;
            phase_q     <= '0;
            atan_addr_q <= '0;
            in_i_q      <= '0;
            in_q_q      <= '0;
            oct_q       <= '0;
            byp_q       <= 1'b0;
            byp_a_q     <= '0;
        end else begin
            ovalid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ivalid) begin
                        in_i_q   <= in_i;
                        in_q_q   <= in_q;
                        iready_q <= 1'b0;
                        state_q  <= ST_FOLD;
                    end
                end
                ST_FOLD: begin
                    oct_q   <= oct_d;
                    byp_q   <= byp_d;
                    byp_a_q <= byp_a_d;
                    state_q <= ST_DIV;
                end
                ST_DIV: begin
                    if (div_done && !div_busy) begin
                        atan_addr_q <= div_quot;
                        state_q     <= ST_LOOK;
                    end
                end
                ST_LOOK: state_q <= ST_CAPT;
                ST_CAPT: begin
                    phase_q  <= phase_d;
                    ovalid_q <= 1'b1;
                    state_q  <= ST_OUT;
                end
                ST_OUT: begin
                    iready_q <= 1'b1;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    iready_q <= 1'b1;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign iready    = iready_q;
    assign ovalid    = ovalid_q;
    assign phase     = phase_q;
    assign atan_addr = atan_addr_q;

endmodule

// File: tb/tb_phase_detect.sv
// Scoreboard bench for phase_detect with a 1-cycle registered arctan ROM model.
`timescale 1ns/1ps
module tb_phase_detect;

    localparam int    W   = 9;
    localparam int    DW  = 16;
    localparam real   PI  = 3.14159265358979323846;
    localparam real   SCL = 1608.0 / PI;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ivalid = 1'b0;
    logic          iready;
    logic [DW-1:0] in_i = '0;
    logic [DW-1:0] in_q = '0;
    logic [W-1:0]  atan_addr;
    logic [15:0]   atan_data = '0;
    logic          ovalid;
    logic [15:0]   phase;
`ifdef PHASE_DETECT_MAG_EN
    logic [DW:0]   mag;
`endif

    always #5 clock = ~clock;

    phase_detect #(.ATAN_WIDTH(W), .DATA_WIDTH(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .ivalid    (ivalid),
        .iready    (iready),
        .in_i      (in_i),
        .in_q      (in_q),
        .atan_addr (atan_addr),
        .atan_data (atan_data),
        .ovalid    (ovalid),
        .phase     (phase)
`ifdef PHASE_DETECT_MAG_EN
        ,
        .mag       (mag)
`endif
    );

    logic [15:0] rom [0:(1<<W)-1];
    always @(posedge clock) atan_data <= rom[atan_addr];

    typedef struct {
        string tag;
        int    ph;
        int    tol;
        int    mg;
        bit    cm;
        int    acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_acc   = 0;

    task automatic chk(input string tag, input int obs, input int exp, input int tol = 0);
        n_tests++;
        if (obs - exp > tol || exp - obs > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Accepts push the pending expectation; output pulses pop and compare.
    always @(negedge clock) begin
        exp_t e;
        cyc = cyc + 1;
        if (!reset && ivalid && iready) begin
            e     = cur;
            e.acc = cyc;
            sb.push_back(e);
            n_acc++;
        end
        if (!reset && ovalid) begin
            if (sb.size() == 0) begin
                chk("spurious_ovalid", int'(ovalid), 0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_phase"}, int'($signed(phase)), e.ph, e.tol);
                chk({e.tag, "_lat"}, cyc - e.acc, 13);
`ifdef PHASE_DETECT_MAG_EN
                if (e.cm) chk({e.tag, "_mag"}, int'(mag), e.mg);
`endif
            end
        end
    end

    task automatic send(input string tag, input int i, input int q, input int ph,
                        input int tol, input bit cm, input int mg);
        int n = 0;
        @(posedge clock); #1;
        while (!iready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 50) chk({tag, "_rdy_timeout"}, int'(iready), 1);
        cur.tag = tag; cur.ph = ph; cur.tol = tol; cur.cm = cm; cur.mg = mg; cur.acc = 0;
        in_i   = DW'(i);
        in_q   = DW'(q);
        ivalid = 1'b1;
        @(posedge clock); #1;
        ivalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        @(posedge clock); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   i0, q0, ex, acc0;
        real  th;

        for (int k = 0; k < (1 << W); k++)
            rom[k] = 16'($rtoi($atan(real'(k) / real'(1 << W)) * SCL + 0.5));

        // reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_iready", int'(iready), 1);
        chk("rst_ovalid", int'(ovalid), 0);
        chk("rst_phase", int'($signed(phase)), 0);
        chk("rst_addr", int'(atan_addr), 0);
        reset = 1'b0;

        // axes, diagonals (ROM bypass), zero, saturation
        send("p0",     1000,     0,     0, 0, 1,  1000); drain();
        send("p90",       0,  1000,   804, 0, 1,  1000); drain();
        send("p180",  -1000,     0,  1608, 0, 1,  1000); drain();
        send("m90",       0, -1000,  -804, 0, 1,  1000); drain();
        send("d45",    1000,  1000,   402, 0, 1,  1375); drain();
        send("dm135", -1000, -1000, -1206, 0, 1,  1375); drain();
        send("dm45",   1000, -1000,  -402, 0, 1,  1375); drain();
        send("zero",      0,     0,     0, 0, 1,     0); drain();
        send("sat",  -32768,     0,  1608, 0, 1, 32767); drain();
        send("m345",   3000,  4000,   475, 1, 1,  5125); drain();

        // angle sweep against atan2 of the integer sample
        for (int k = 0; k < 256; k++) begin
            th = 2.0 * PI * real'(k) / 256.0;
            i0 = int'(20000.0 * $cos(th));
            q0 = int'(20000.0 * $sin(th));
            ex = int'($atan2(real'(q0), real'(i0)) * SCL);
            send("sweep", i0, q0, ex, 2, 0, 0);
        end
        drain();

        // ivalid held high: only IDLE cycles accept
        acc0 = n_acc;
        cur.tag = "stream"; cur.ph = 402; cur.tol = 0; cur.cm = 1; cur.mg = 1375; cur.acc = 0;
        in_i   = DW'(1000);
        in_q   = DW'(1000);
        ivalid = 1'b1;
        repeat (56) @(posedge clock);
        #1;
        ivalid = 1'b0;
        chk("stream_accepts", n_acc - acc0, 4);
        drain();

        // reset in the middle of the divide aborts the sample
        send("abort", 1000, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        sb.delete();
        chk("abort_iready", int'(iready), 1);
        chk("abort_ovalid", int'(ovalid), 0);
        repeat (20) @(posedge clock);
        send("post_rst", 0, -1000, -804, 0, 1, 1000); drain();

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
